// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared widths, M-stage FSM states and the W-stage bundle of
//               the 8-bit dual-write-port pipelined processor.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int WORD_W = 8;
  localparam int RA_W   = 3;

  // Memory access sequencer states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Everything the write-back stage needs from one instruction
  typedef struct packed {
    logic [WORD_W-1:0] ReadData;
    logic [WORD_W-1:0] ALUResult;
    logic [RA_W-1:0]   WA3;
    logic [RA_W-1:0]   WA4;
    logic              RegWriteA;
    logic              RegWriteB;
    logic              MemtoReg;
  } wb_bundle_t;

  // A bubble writes nothing and carries no data
  localparam wb_bundle_t WB_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/mem_stage_w_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_w_if
// Description : Request/ready data-memory bus between the M stage (master)
//               and a variable-latency data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_w_if;
  import pipe_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface
`default_nettype wire

// File: rtl/pipe_w_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_w_reg
// Description : M->W pipeline register. Loads the completed bundle or a
//               bubble every cycle; clears to zero on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_w_reg
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_bubble,
  input  wb_bundle_t d,
  output wb_bundle_t q
);

  wb_bundle_t r_q;

  // W register: bubble when the M instruction does not complete this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (load_bubble) begin
      r_q <= WB_BUBBLE;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage_w.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_w
// Description : Memory stage plus M->W register. Runs loads/stores against a
//               variable-latency memory, stalls the front end while waiting,
//               and aborts with a sticky MemErr after TIMEOUT wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_w
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] RD1M,
  input  logic [WORD_W-1:0] ALUResultM,
  input  logic [RA_W-1:0]   WA3M,
  input  logic [RA_W-1:0]   WA4M,
  input  logic              RegWriteAM,
  input  logic              RegWriteBM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  mem_stage_w_if.master     mem,
  output logic              StallM,
  output logic [WORD_W-1:0] ReadDataW,
  output logic [WORD_W-1:0] ALUResultW,
  output logic [RA_W-1:0]   WA3W,
  output logic [RA_W-1:0]   WA4W,
  output logic              RegWriteAW,
  output logic              RegWriteBW,
  output logic              MemtoRegW,
  output logic              MemErr
);

  localparam logic [7:0] c_timeout_cnt = 8'(TIMEOUT);

  mem_state_t r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_mem_err, w_mem_err_nxt;
  logic       w_memop;
  logic       w_timeout_hit;
  logic       w_bubble;
  wb_bundle_t w_wb_nxt;
  wb_bundle_t w_wb_q;

  // A load+store combination is treated as a load only
  assign w_memop       = MemtoRegM | MemWriteM;
  assign w_timeout_hit = (r_state == WAIT) && (r_cnt == c_timeout_cnt);

  assign mem.mem_req   = w_memop & ~reset;
  assign mem.mem_we    = MemWriteM & ~MemtoRegM;
  assign mem.mem_addr  = ALUResultM;
  assign mem.mem_wdata = RD1M;

  // Hold the front end until the memory answers or the wait budget runs out
  assign StallM = w_memop & ~mem.mem_ready & ~w_timeout_hit & ~reset;

  // Bundle handed to W when the instruction leaves M successfully
  always_comb begin
    w_wb_nxt           = WB_BUBBLE;
    w_wb_nxt.ReadData  = MemtoRegM ? mem.mem_rdata : '0;
    w_wb_nxt.ALUResult = ALUResultM;
    w_wb_nxt.WA3       = WA3M;
    w_wb_nxt.WA4       = WA4M;
    w_wb_nxt.RegWriteA = RegWriteAM;
    w_wb_nxt.RegWriteB = RegWriteBM;
    w_wb_nxt.MemtoReg  = MemtoRegM;
  end

  // Next state, wait counter, error flag and bubble select
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mem_err_nxt = r_mem_err;
    w_bubble      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop && !mem.mem_ready) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = 8'd1;
          w_bubble    = 1'b1;
        end
      end
      WAIT: begin
        // A late ready on the final wait cycle still counts as success
        if (mem.mem_ready || !w_memop) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (w_timeout_hit) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = 8'd0;
          w_mem_err_nxt = 1'b1;
          w_bubble      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
          w_bubble  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State, counter and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mem_err <= w_mem_err_nxt;
    end
  end

  pipe_w_reg u_w_reg (
    .clk         (clk),
    .reset       (reset),
    .load_bubble (w_bubble),
    .d           (w_wb_nxt),
    .q           (w_wb_q)
  );

  assign ReadDataW  = w_wb_q.ReadData;
  assign ALUResultW = w_wb_q.ALUResult;
  assign WA3W       = w_wb_q.WA3;
  assign WA4W       = w_wb_q.WA4;
  assign RegWriteAW = w_wb_q.RegWriteA;
  assign RegWriteBW = w_wb_q.RegWriteB;
  assign MemtoRegW  = w_wb_q.MemtoReg;
  assign MemErr     = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_w.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_w
// Description : Self-checking bench for mem_stage_w: directed vector table,
//               randomized instructions against an instruction-level model,
//               and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_w;
  import pipe_pkg::*;

  localparam int TIMEOUT = 15;
  localparam int NEVER   = 1000;

  typedef struct {
    logic [7:0] alu;
    logic [7:0] rd1;
    logic [7:0] rdata;
    logic [2:0] wa3;
    logic [2:0] wa4;
    logic       rwa;
    logic       rwb;
    logic       mtr;
    logic       mw;
    int         lat;   // not-ready cycles before mem_ready rises
  } instr_t;

  typedef struct {
    int         nstall;
    wb_bundle_t w;
    logic       err;
    logic       we;
  } exp_t;

  typedef struct {
    instr_t in;
    exp_t   ex;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] RD1M, ALUResultM;
  logic [2:0] WA3M, WA4M;
  logic RegWriteAM, RegWriteBM, MemtoRegM, MemWriteM;
  logic StallM;
  logic [7:0] ReadDataW, ALUResultW;
  logic [2:0] WA3W, WA4W;
  logic RegWriteAW, RegWriteBW, MemtoRegW, MemErr;
  wb_bundle_t got;

  int n_checks = 0;
  int n_errors = 0;
  logic model_err = 1'b0;
  vec_t vecs[9];

  mem_stage_w_if mif ();

  mem_stage_w #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .RD1M       (RD1M),
    .ALUResultM (ALUResultM),
    .WA3M       (WA3M),
    .WA4M       (WA4M),
    .RegWriteAM (RegWriteAM),
    .RegWriteBM (RegWriteBM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .mem        (mif),
    .StallM     (StallM),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .WA3W       (WA3W),
    .WA4W       (WA4W),
    .RegWriteAW (RegWriteAW),
    .RegWriteBW (RegWriteBW),
    .MemtoRegW  (MemtoRegW),
    .MemErr     (MemErr)
  );

  always #5 clk = ~clk;

  assign got = {ReadDataW, ALUResultW, WA3W, WA4W, RegWriteAW, RegWriteBW, MemtoRegW};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic instr_t mk_in(logic [7:0] alu, logic [7:0] rd1, logic [2:0] wa3,
                                   logic [2:0] wa4, logic rwa, logic rwb, logic mtr,
                                   logic mw, logic [7:0] rdata, int lat);
    instr_t i;
    i.alu = alu; i.rd1 = rd1; i.wa3 = wa3; i.wa4 = wa4; i.rwa = rwa; i.rwb = rwb;
    i.mtr = mtr; i.mw = mw; i.rdata = rdata; i.lat = lat;
    return i;
  endfunction

  function automatic exp_t mk_ex(int nstall, logic [7:0] rd, logic [7:0] alu, logic [2:0] wa3,
                                 logic [2:0] wa4, logic rwa, logic rwb, logic mtr,
                                 logic err, logic we);
    exp_t e;
    e.nstall = nstall;
    e.w      = {rd, alu, wa3, wa4, rwa, rwb, mtr};
    e.err    = err;
    e.we     = we;
    return e;
  endfunction

  // Instruction-level reference: how long it stalls and what reaches W
  function automatic exp_t model(instr_t in, logic err_prev);
    exp_t e;
    logic memop;
    memop    = in.mtr | in.mw;
    e.we     = in.mw & ~in.mtr;
    e.err    = err_prev;
    e.w      = {(in.mtr ? in.rdata : 8'h00), in.alu, in.wa3, in.wa4, in.rwa, in.rwb, in.mtr};
    e.nstall = 0;
    if (memop) begin
      if (in.lat <= TIMEOUT) begin
        e.nstall = in.lat;
      end else begin
        e.nstall = TIMEOUT;
        e.w      = '0;
        e.err    = 1'b1;
      end
    end
    return e;
  endfunction

  // Present one instruction in M and follow it until it leaves M
  task automatic run_instr(input instr_t in, input exp_t ex);
    logic memop;
    memop      = in.mtr | in.mw;
    RD1M       = in.rd1;
    ALUResultM = in.alu;
    WA3M       = in.wa3;
    WA4M       = in.wa4;
    RegWriteAM = in.rwa;
    RegWriteBM = in.rwb;
    MemtoRegM  = in.mtr;
    MemWriteM  = in.mw;
    for (int c = 0; c <= ex.nstall; c++) begin
      if (!memop) begin
        mif.mem_ready = 1'($urandom_range(0, 1));
        mif.mem_rdata = 8'($urandom);
      end else if (c >= in.lat) begin
        mif.mem_ready = 1'b1;
        mif.mem_rdata = in.rdata;
      end else begin
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 8'($urandom);
      end
      @(negedge clk);
      chk("stall", StallM, (c < ex.nstall));
      chk("mem_req", mif.mem_req, memop);
      if (memop && c == 0) begin
        chk("mem_we", mif.mem_we, ex.we);
        chk("mem_addr", mif.mem_addr, in.alu);
        chk("mem_wdata", mif.mem_wdata, in.rd1);
      end
      @(posedge clk);
      #1;
      if (c < ex.nstall) begin
        chk("w_bubble", got, '0);
        chk("err_hold", MemErr, model_err);
      end else begin
        chk("w_bundle", got, ex.w);
        chk("mem_err", MemErr, ex.err);
      end
    end
    model_err = ex.err;
  endtask

  // Reset with a load pending in M: request and stall must be suppressed
  task automatic do_reset();
    reset      = 1'b1;
    MemtoRegM  = 1'b1;
    MemWriteM  = 1'b0;
    mif.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stall", StallM, 1'b0);
    chk("rst_req", mif.mem_req, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_w", got, '0);
    chk("rst_err", MemErr, 1'b0);
    reset     = 1'b0;
    model_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t ri;
    exp_t   re;
    int     sel;

    // Directed table with hand-computed expectations
    vecs[0] = '{mk_in(8'h5A, 8'h11, 3'd3, 3'd0, 1, 0, 0, 0, 8'hAB, 0),
                mk_ex(0, 8'h00, 8'h5A, 3'd3, 3'd0, 1, 0, 0, 0, 0)};
    vecs[1] = '{mk_in(8'h10, 8'h00, 3'd2, 3'd0, 1, 0, 1, 0, 8'hC3, 0),
                mk_ex(0, 8'hC3, 8'h10, 3'd2, 3'd0, 1, 0, 1, 0, 0)};
    vecs[2] = '{mk_in(8'h33, 8'h00, 3'd4, 3'd0, 1, 0, 1, 0, 8'h7E, 3),
                mk_ex(3, 8'h7E, 8'h33, 3'd4, 3'd0, 1, 0, 1, 0, 0)};
    vecs[3] = '{mk_in(8'h20, 8'h99, 3'd0, 3'd5, 0, 1, 0, 1, 8'hEE, 0),
                mk_ex(0, 8'h00, 8'h20, 3'd0, 3'd5, 0, 1, 0, 0, 1)};
    vecs[4] = '{mk_in(8'h44, 8'h00, 3'd6, 3'd0, 1, 0, 1, 0, 8'h5C, 15),
                mk_ex(15, 8'h5C, 8'h44, 3'd6, 3'd0, 1, 0, 1, 0, 0)};
    vecs[5] = '{mk_in(8'h21, 8'h77, 3'd1, 3'd0, 1, 0, 1, 1, 8'h3D, 1),
                mk_ex(1, 8'h3D, 8'h21, 3'd1, 3'd0, 1, 0, 1, 0, 0)};
    vecs[6] = '{mk_in(8'h55, 8'h00, 3'd7, 3'd0, 1, 0, 1, 0, 8'h12, NEVER),
                mk_ex(15, 8'h00, 8'h00, 3'd0, 3'd0, 0, 0, 0, 1, 0)};
    vecs[7] = '{mk_in(8'h66, 8'h00, 3'd0, 3'd2, 0, 1, 0, 0, 8'h00, 0),
                mk_ex(0, 8'h00, 8'h66, 3'd0, 3'd2, 0, 1, 0, 1, 0)};
    vecs[8] = '{mk_in(8'h08, 8'h12, 3'd0, 3'd1, 0, 1, 0, 1, 8'hFF, 2),
                mk_ex(2, 8'h00, 8'h08, 3'd0, 3'd1, 0, 1, 0, 1, 1)};

    reset = 1'b1;
    RD1M = '0; ALUResultM = '0; WA3M = '0; WA4M = '0;
    RegWriteAM = 1'b0; RegWriteBM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    do_reset();

    foreach (vecs[i]) run_instr(vecs[i].in, vecs[i].ex);

    // Randomized instructions against the reference model
    do_reset();
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 3));
      ri  = mk_in(8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), (sel == 1 || sel == 3), (sel == 2 || sel == 3),
                  8'($urandom), 0);
      case ($urandom_range(0, 9))
        6:       ri.lat = TIMEOUT - 1;
        7:       ri.lat = TIMEOUT;
        8:       ri.lat = TIMEOUT + 1;
        default: ri.lat = int'($urandom_range(0, 3));
      endcase
      re = model(ri, model_err);
      run_instr(ri, re);
    end

    // Reset in the second wait cycle of an access that never completes
    run_instr(vecs[6].in, model(vecs[6].in, model_err));
    RD1M = 8'h00; ALUResultM = 8'h70; WA3M = 3'd2; WA4M = 3'd0;
    RegWriteAM = 1'b1; RegWriteBM = 1'b0; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    mif.mem_ready = 1'b0;
    @(posedge clk);   // IDLE -> WAIT
    #1;
    @(posedge clk);   // first wait cycle
    #1;
    chk("mw_stall", StallM, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("mw_rst_stall", StallM, 1'b0);
    chk("mw_rst_req", mif.mem_req, 1'b0);
    @(posedge clk);
    #1;
    chk("mw_rst_w", got, '0);
    chk("mw_rst_err", MemErr, 1'b0);
    reset     = 1'b0;
    model_err = 1'b0;
    ri = mk_in(8'h71, 8'h00, 3'd5, 3'd0, 1, 0, 1, 0, 8'hA5, 1);
    run_instr(ri, model(ri, model_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_w.md
Name: mem_stage_w

Overview:
- Memory stage plus M->W pipeline register of the 8-bit dual-write-port pipelined processor.
- Consumes the M-stage bundle produced by the E->M register and performs the load/store against a variable-latency data memory through a req/ready handshake.
- Raises StallM while an access is outstanding and registers the W-stage bundle (read data, ALU result, both write addresses, both write enables, MemtoReg).
- Includes a wait-cycle timeout with a sticky error flag.

Parameters:
- WORD_W, 8, data/address width.
- RA_W, 3, register-file address width.
- TIMEOUT, 15, maximum wait cycles before an access is aborted (1..255).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- RD1M  in  WORD_W  store data.
- ALUResultM  in  WORD_W  memory address / ALU result.
- WA3M, WA4M  in  RA_W  write addresses, ports A/B.
- RegWriteAM, RegWriteBM  in  1  write enables.
- MemtoRegM  in  1  load.
- MemWriteM  in  1  store.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write.
- mem_addr  out  WORD_W  equals ALUResultM.
- mem_wdata  out  WORD_W  equals RD1M.
- mem_rdata  in  WORD_W  read data, valid when mem_ready=1.
- mem_ready  in  1  access completes this cycle.
- StallM  out  1  freeze F/D/E and the E->M register.
- ReadDataW, ALUResultW  out  WORD_W  W-stage data.
- WA3W, WA4W  out  RA_W  W-stage write addresses.
- RegWriteAW, RegWriteBW, MemtoRegW  out  1  W-stage controls.
- MemErr  out  1  sticky timeout flag.

Behaviour:
- Memory op: memop = MemtoRegM | MemWriteM. If both are set, the op is treated as a load only (mem_we=0).
- FSM states: IDLE, WAIT. Wait counter: 8 bits.
- mem_req = memop & !reset (combinational, asserted in IDLE and WAIT).
- mem_we = MemWriteM & !MemtoRegM.
- StallM = memop & !mem_ready & !timeout_hit, where timeout_hit = (state==WAIT & cnt==TIMEOUT).
- IDLE, memop=0:
  - Advance; W <= M bundle; ReadDataW <= 0.
  - Latency: 1 cycle.
- IDLE, memop=1, mem_ready=1:
  - Zero-wait access; advance.
  - ReadDataW <= mem_rdata for loads, 0 for stores.
- IDLE, memop=1, mem_ready=0:
  - Go to WAIT with cnt <= 1.
  - W <= bubble (all RegWrite=0, MemtoRegW=0, data/addresses 0).
- WAIT, mem_ready=1:
  - Complete as in the zero-wait case; go to IDLE; cnt <= 0.
- WAIT, mem_ready=0, cnt<TIMEOUT:
  - cnt <= cnt+1; bubble into W; StallM=1.
- WAIT, mem_ready=0, cnt==TIMEOUT:
  - Abort: StallM=0, so the instruction leaves M.
  - W <= bubble, so the instruction's register writes are dropped.
  - MemErr <= 1; go to IDLE; cnt <= 0.
- Simultaneous events: mem_ready=1 in the same cycle as cnt==TIMEOUT counts as success; the access completes and MemErr is unchanged.
- Stores never write the register file through ReadDataW; RegWriteA/B pass through unchanged, since a store may still update a base register via port B.
- MemErr clears only on reset.
- Reset (any cycle, including mid-WAIT):
  - state=IDLE, cnt=0, MemErr=0.
  - All W outputs 0; mem_req=0; StallM forced to 0.
  - The outstanding access is abandoned. The memory must tolerate withdrawal of the request.
- The M bundle must remain stable while StallM=1; that is guaranteed by the hazard unit freezing the E->M register.

Decomposition:
- Shared package pipe_pkg holds:
  - WORD_W, RA_W.
  - typedef mem_state_t {IDLE, WAIT}.
  - packed struct wb_bundle_t {ReadData, ALUResult, WA3, WA4, RegWriteA, RegWriteB, MemtoReg}.
  - Constant WB_BUBBLE, all zero.
- One sub-module: pipe_w_reg, the M->W register. It loads either the next bundle or WB_BUBBLE, and clears to zero on reset.
- The FSM, counter and handshake logic stay in mem_stage_w.

Test Plan:
- ALU op (ALUResultM=0x5A, WA3M=3, RegWriteAM=1, memop=0):
  - Next cycle ALUResultW=0x5A, WA3W=3, RegWriteAW=1, ReadDataW=0.
  - No mem_req, StallM=0.
- Load, zero wait (ALUResultM=0x10, MemtoRegM=1, mem_ready=1, mem_rdata=0xC3):
  - mem_req=1, mem_we=0, mem_addr=0x10.
  - Next cycle ReadDataW=0xC3, MemtoRegW=1, no stall.
- Load with 3 wait cycles (mem_ready low for 3 cycles, then high with 0x7E):
  - StallM=1 for exactly 3 cycles, with 3 bubbles in W (RegWriteAW=0).
  - Then ReadDataW=0x7E; MemErr=0.
- Store (MemWriteM=1, RD1M=0x99, ALUResultM=0x20, RegWriteBM=1, WA4M=5, mem_ready=1):
  - mem_we=1, mem_wdata=0x99, mem_addr=0x20.
  - W gets RegWriteBW=1, WA4W=5, ReadDataW=0.
- Timeout (TIMEOUT=15, mem_ready never asserted):
  - StallM high for 15 cycles, low on the cycle cnt==15.
  - W carries only bubbles; MemErr=1 and stays 1 on subsequent ops until reset.
  - Separately: mem_ready=1 at cnt==15 completes the load and MemErr stays 0.
- Reset mid-WAIT (reset asserted in 2nd wait cycle):
  - Next edge: all W outputs 0, StallM=0, mem_req=0, MemErr=0.
  - A fresh load after reset completes normally.
